// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_dot_sequencer
// Description : Initiator for an external MultiplyAdd_NR unit using the
//               inReady/outReady handshake. It computes a signed dot product
//               of len operand pairs. Each pair is issued to the MAC together
//               with the running accumulator on C. The returned RES becomes
//               the accumulator for the next element. Only one MAC transaction
//               is outstanding at a time, so any MAC pipeline depth works,
//               including a zero-latency (combinational) MAC.
//
// Ports       : clk, reset       clock / asynchronous active-high reset
//               enable           clock enable; low freezes all state
//               start, len       start pulse (IDLE only) and element count
//               inValid/inA/inB  operand pair stream
//               inAccept         operand pair consumed this cycle
//               mA, mB, mC       MAC operand outputs (C = accumulator)
//               mInReady         MAC issue strobe
//               mRES, mOutReady  MAC result and result strobe
//               result           final dot product (held until next finish)
//               resultValid      one-cycle pulse qualifying result
//               busy             high in every state except IDLE
//               overflow         sticky saturation flag
//
// Options     : MAC_DOT_SEQUENCER_SATURATE_EN
//               Defined   : captures saturate to the IN_A_WIDTH signed range
//                           and set overflow when clipping occurs.
//               Undefined : captures wrap to IN_A_WIDTH bits; overflow is 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module mac_dot_sequencer #(
    parameter int IN_M_WIDTH = 10,
    parameter int IN_A_WIDTH = 20,
    parameter int OUT_WIDTH  = 21,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  inValid,
    input  logic [IN_M_WIDTH-1:0] inA,
    input  logic [IN_M_WIDTH-1:0] inB,
    output logic                  inAccept,
    output logic [IN_M_WIDTH-1:0] mA,
    output logic [IN_M_WIDTH-1:0] mB,
    output logic [IN_A_WIDTH-1:0] mC,
    output logic                  mInReady,
    input  logic [OUT_WIDTH-1:0]  mRES,
    input  logic                  mOutReady,
    output logic [IN_A_WIDTH-1:0] result,
    output logic                  resultValid,
    output logic                  busy,
    output logic                  overflow
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [LEN_WIDTH-1:0] C_CNT_ONE = LEN_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic [1:0]            state_q,    state_d;
    logic [LEN_WIDTH-1:0]  cnt_q,      cnt_d;
    logic [IN_A_WIDTH-1:0] acc_q,      acc_d;
    logic [IN_A_WIDTH-1:0] result_q,   result_d;
    logic                  overflow_q, overflow_d;

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    logic w_issue;
    logic w_capture;

    // An issue happens whenever the MAC is offered a valid pair in ISSUE.
    assign w_issue = enable & inValid & (state_q == ST_ISSUE);

    // A result is taken in WAIT, or in the issue cycle itself when the MAC is
    // combinational and answers immediately. Any other outReady (including a
    // stale one from a transaction abandoned by reset) is ignored.
    assign w_capture = mOutReady &
                       (w_issue | (enable & (state_q == ST_WAIT)));

    // ------------------------------------------------------------------------
    // Result fitting: mRES -> IN_A_WIDTH
    // ------------------------------------------------------------------------
    logic [IN_A_WIDTH-1:0] w_fit;
    logic                  w_clip;

`ifdef MAC_DOT_SEQUENCER_SATURATE_EN
    localparam logic [IN_A_WIDTH-1:0] C_ACC_MAX = {1'b0, {(IN_A_WIDTH-1){1'b1}}};
    localparam logic [IN_A_WIDTH-1:0] C_ACC_MIN = {1'b1, {(IN_A_WIDTH-1){1'b0}}};

    // The value is representable only if every bit from the target sign bit
    // upward is a copy of the same sign.
    logic [OUT_WIDTH-IN_A_WIDTH:0] w_upper;
    assign w_upper = mRES[OUT_WIDTH-1:IN_A_WIDTH-1];
    assign w_clip  = ~((&w_upper) | ~(|w_upper));

    always_comb begin
        w_fit = mRES[IN_A_WIDTH-1:0];
        if (w_clip) begin
            w_fit = mRES[OUT_WIDTH-1] ? C_ACC_MIN : C_ACC_MAX;
        end
    end
`else
    // Two's-complement wrap: keep the low bits, discard the extension.
    assign w_fit  = mRES[IN_A_WIDTH-1:0];
    assign w_clip = 1'b0;

    generate
        if (OUT_WIDTH > IN_A_WIDTH) begin : g_res_hi
            logic w_unused_res_hi;
            assign w_unused_res_hi = ^mRES[OUT_WIDTH-1:IN_A_WIDTH];
        end
    endgenerate
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            cnt_d      = len;
                            acc_d      = '0;
                            overflow_d = 1'b0;
                            state_d    = ST_ISSUE;
                        end else begin
                            // Empty vector: the dot product is zero.
                            result_d = '0;
                            state_d  = ST_DONE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (inValid) begin
                        state_d = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Hold; mC keeps presenting acc until the result returns
                    // because the MAC adds C at its output stage.
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Capture overrides the ISSUE->WAIT move for a zero-latency MAC.
            if (w_capture) begin
                acc_d = w_fit;
                cnt_d = cnt_q - C_CNT_ONE;
                if (w_clip) begin
                    overflow_d = 1'b1;
                end
                if (cnt_q == C_CNT_ONE) begin
                    result_d = w_fit;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_ISSUE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mA          = inA;
    assign mB          = inB;
    assign mC          = acc_q;
    assign mInReady    = w_issue;
    assign inAccept    = w_issue;
    assign result      = result_q;
    assign resultValid = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign overflow    = overflow_q;

endmodule
`default_nettype wire
